// File: rtl/enc8to3_scan.sv
// Sequential 8-to-3 encoder: loads a request word and emits the index of each
// set bit, one per valid/ready handshake, lowest- or highest-index first.
module enc8to3_scan #(
    parameter int PRIORITY_HIGH = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [7:0] w_i,
    input  logic       ready_i,
    output logic [2:0] y_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       zero_o,
    output logic [3:0] count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] pend_q;
    logic [2:0] y_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic       zero_q;
    logic [3:0] count_q;

    logic [7:0] rem_d;
    logic [2:0] next_idx_d;
    logic [2:0] load_idx_d;

    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH == 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Bits left after the presented index is retired, and the index to show next.
    always_comb begin
        rem_d      = pend_q & ~(8'd1 << y_q);
        next_idx_d = prio_idx(rem_d);
        load_idx_d = prio_idx(w_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            y_q     <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            count_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (en_i) begin
                        pend_q  <= w_i;
                        count_q <= 4'd0;
                        zero_q  <= (w_i == 8'd0);
                        busy_q  <= 1'b1;
                        if (w_i != 8'd0) begin
                            state_q <= SCAN;
                            y_q     <= load_idx_d;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (valid_q && ready_i) begin
                        pend_q  <= rem_d;
                        count_q <= count_q + 4'd1;
                        if (rem_d != 8'd0) begin
                            y_q <= next_idx_d;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y_o     = y_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign zero_o  = zero_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_enc8to3_scan.sv
// Directed bench for enc8to3_scan: one instance per priority order, shared stimulus.
module tb_enc8to3_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] w;
    logic       ready;

    logic [2:0] y0, y1;
    logic       valid0, valid1, busy0, busy1, done0, done1, zero0, zero1;
    logic [3:0] count0, count1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc8to3_scan #(.PRIORITY_HIGH(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .w_i(w), .ready_i(ready),
        .y_o(y0), .valid_o(valid0), .busy_o(busy0), .done_o(done0),
        .zero_o(zero0), .count_o(count0)
    );

    enc8to3_scan #(.PRIORITY_HIGH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .w_i(w), .ready_i(ready),
        .y_o(y1), .valid_o(valid1), .busy_o(busy1), .done_o(done1),
        .zero_o(zero1), .count_o(count1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; w = 8'h00; ready = 1'b0;
        step(); step();
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_y", 32'(y0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_zero", 32'(zero0), 0);
        chk("rst_count", 32'(count0), 0);
        rst = 1'b0;

        // Two set bits, consumer always ready
        w = 8'b0010_0100; en = 1'b1; ready = 1'b1;
        step(); en = 1'b0;
        chk("t1_valid_a", 32'(valid0), 1);
        chk("t1_y_a", 32'(y0), 2);
        chk("t1_busy", 32'(busy0), 1);
        chk("t1_count_a", 32'(count0), 0);
        step();
        chk("t1_valid_b", 32'(valid0), 1);
        chk("t1_y_b", 32'(y0), 5);
        chk("t1_count_b", 32'(count0), 1);
        step();
        chk("t1_valid_end", 32'(valid0), 0);
        chk("t1_done", 32'(done0), 1);
        chk("t1_count_end", 32'(count0), 2);
        chk("t1_zero", 32'(zero0), 0);
        step();
        chk("t1_done_pulse", 32'(done0), 0);
        chk("t1_idle_busy", 32'(busy0), 0);

        // Same word with back-pressure 0,0,1,0,1
        w = 8'b0010_0100; en = 1'b1; ready = 1'b0;
        step(); en = 1'b0;
        chk("t2_y_load", 32'(y0), 2);
        ready = 1'b0; step();
        chk("t2_stall1_valid", 32'(valid0), 1);
        chk("t2_stall1_y", 32'(y0), 2);
        ready = 1'b0; step();
        chk("t2_stall2_y", 32'(y0), 2);
        chk("t2_stall2_count", 32'(count0), 0);
        ready = 1'b1; step();
        chk("t2_hs1_y", 32'(y0), 5);
        chk("t2_hs1_count", 32'(count0), 1);
        ready = 1'b0; step();
        chk("t2_stall3_valid", 32'(valid0), 1);
        chk("t2_stall3_y", 32'(y0), 5);
        chk("t2_stall3_count", 32'(count0), 1);
        ready = 1'b1; step();
        chk("t2_done", 32'(done0), 1);
        chk("t2_valid_end", 32'(valid0), 0);
        chk("t2_count", 32'(count0), 2);
        step();

        // Zero word, then a load held across the DONE cycle
        w = 8'h00; en = 1'b1; ready = 1'b1;
        step();
        chk("t3_done", 32'(done0), 1);
        chk("t3_zero", 32'(zero0), 1);
        chk("t3_valid", 32'(valid0), 0);
        chk("t3_count", 32'(count0), 0);
        chk("t3_busy", 32'(busy0), 1);
        w = 8'h08;
        step();
        chk("t3_ignored_valid", 32'(valid0), 0);
        chk("t3_idle_busy", 32'(busy0), 0);
        chk("t3_zero_held", 32'(zero0), 1);
        step(); en = 1'b0;
        chk("t3_reload_valid", 32'(valid0), 1);
        chk("t3_reload_y", 32'(y0), 3);
        chk("t3_reload_zero", 32'(zero0), 0);
        step();
        chk("t3_reload_done", 32'(done0), 1);
        chk("t3_reload_count", 32'(count0), 1);
        step();

        // All bits set: eight indices back to back
        w = 8'hFF; en = 1'b1; ready = 1'b1;
        step(); en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_valid_%0d", i), 32'(valid0), 1);
            chk($sformatf("t4_y_%0d", i), 32'(y0), 32'(i));
            step();
        end
        chk("t4_done", 32'(done0), 1);
        chk("t4_count", 32'(count0), 8);
        chk("t4_valid_end", 32'(valid0), 0);
        step();

        // High-first priority; load attempt during SCAN must be ignored
        w = 8'h81; en = 1'b1; ready = 1'b0;
        step(); en = 1'b0;
        chk("t5_hi_y_a", 32'(y1), 7);
        chk("t5_lo_y_a", 32'(y0), 0);
        w = 8'h10; en = 1'b1;
        step(); en = 1'b0; w = 8'h00;
        chk("t5_hi_y_hold", 32'(y1), 7);
        chk("t5_hi_count_hold", 32'(count1), 0);
        ready = 1'b1; step();
        chk("t5_hi_y_b", 32'(y1), 0);
        chk("t5_hi_count_b", 32'(count1), 1);
        chk("t5_lo_y_b", 32'(y0), 7);
        step();
        chk("t5_hi_done", 32'(done1), 1);
        chk("t5_hi_count", 32'(count1), 2);
        chk("t5_hi_valid_end", 32'(valid1), 0);
        step();
        chk("t5_hi_no_extra", 32'(valid1), 0);
        chk("t5_hi_idle", 32'(busy1), 0);

        // Mid-scan reset, then a fresh single-bit load
        w = 8'h0F; en = 1'b1; ready = 1'b1;
        step(); en = 1'b0;
        chk("t6_y_a", 32'(y0), 0);
        step();
        chk("t6_y_b", 32'(y0), 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t6_rst_valid", 32'(valid0), 0);
        chk("t6_rst_busy", 32'(busy0), 0);
        chk("t6_rst_count", 32'(count0), 0);
        w = 8'h08; en = 1'b1;
        step(); en = 1'b0;
        chk("t6_new_y", 32'(y0), 3);
        chk("t6_new_valid", 32'(valid0), 1);
        step();
        chk("t6_new_done", 32'(done0), 1);
        chk("t6_new_count", 32'(count0), 1);
        step();
        chk("t6_end_valid", 32'(valid0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
